// File: rtl/osyrys64_pkg.sv
// Shared types and opcode constants for the osyrys-64 decode/dispatch stage.
package osyrys64_pkg;

  typedef enum logic [3:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluXor,
    AluSll,
    AluSrl,
    AluSra,
    AluSlt,
    AluSltu
  } alu_control_t;

  localparam logic [6:0] OPCODE_OP         = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM     = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD       = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE      = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH     = 7'b1100011;
  localparam logic [6:0] OPCODE_NPU_MATMUL = 7'b0001011;
  localparam logic [6:0] OPCODE_NPU_CONV   = 7'b0101011;

  typedef struct packed {
    alu_control_t alu_control;
    logic         reg_write_en;
    logic         alu_src;
    logic         mem_read;
    logic         mem_write;
    logic         mem_to_reg;
    logic         branch;
    logic [4:0]   rd;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic         illegal;
  } decode_ctrl_t;

  typedef logic [1:0] npu_disp_state_t;

  localparam npu_disp_state_t StIdle = 2'd0;
  localparam npu_disp_state_t StReq  = 2'd1;
  localparam npu_disp_state_t StWait = 2'd2;

  // funct3 -> ALU op for the non-alternate (funct7[5]=0) encodings.
  function automatic alu_control_t base_alu_op(logic [2:0] funct3);
    case (funct3)
      3'b000:  return AluAdd;
      3'b001:  return AluSll;
      3'b010:  return AluSlt;
      3'b011:  return AluSltu;
      3'b100:  return AluXor;
      3'b101:  return AluSrl;
      3'b110:  return AluOr;
      default: return AluAnd;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode_comb.sv
// Purely combinational instruction decoder: instruction word -> decode_ctrl_t plus NPU flags.
module instr_decode_comb
  import osyrys64_pkg::*;
#(
  parameter int unsigned EXT_ALU = 1
) (
  input  logic [31:0]                    instr_i,
  output logic [$bits(decode_ctrl_t)-1:0] ctrl_o,
  output logic                           is_npu_o,
  output logic                           is_conv_o
);

  decode_ctrl_t ctrl;
  logic         legal;
  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic [6:0]   funct7;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  always_comb begin
    ctrl             = '0;
    ctrl.alu_control = AluAdd;
    // Register fields are forwarded raw; consumers gate them with the enables.
    ctrl.rd          = instr_i[11:7];
    ctrl.rs1         = instr_i[19:15];
    ctrl.rs2         = instr_i[24:20];
    legal            = 1'b0;
    is_npu_o         = 1'b0;
    is_conv_o        = 1'b0;

    case (opcode)
      OPCODE_OP: begin
        ctrl.reg_write_en = 1'b1;
        if (funct7 == 7'h00) begin
          ctrl.alu_control = base_alu_op(funct3);
          legal            = 1'b1;
        end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
          ctrl.alu_control = AluSub;
          legal            = 1'b1;
        end else if (funct7 == 7'h20 && funct3 == 3'b101) begin
          ctrl.alu_control = AluSra;
          legal            = 1'b1;
        end
      end
      OPCODE_OP_IMM: begin
        ctrl.reg_write_en = 1'b1;
        ctrl.alu_src      = 1'b1;
        ctrl.alu_control  = base_alu_op(funct3);
        legal             = 1'b1;
        // RV64 shifts carry a 6-bit shamt; only instr[30] may be set above it.
        if (funct3 == 3'b001) begin
          legal = (instr_i[31:26] == 6'b000000);
        end else if (funct3 == 3'b101) begin
          legal = (instr_i[31:26] == 6'b000000) || (instr_i[31:26] == 6'b010000);
          if (instr_i[30]) ctrl.alu_control = AluSra;
        end
      end
      OPCODE_LOAD: begin
        ctrl.alu_src      = 1'b1;
        ctrl.mem_read     = 1'b1;
        ctrl.mem_to_reg   = 1'b1;
        ctrl.reg_write_en = 1'b1;
        legal             = (funct3 != 3'b111);
      end
      OPCODE_STORE: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        legal          = !funct3[2];
      end
      OPCODE_BRANCH: begin
        ctrl.alu_control = AluSub;
        ctrl.branch      = 1'b1;
        legal            = (funct3[2:1] != 2'b01);
      end
      OPCODE_NPU_MATMUL: begin
        is_npu_o = 1'b1;
        legal    = 1'b1;
      end
      OPCODE_NPU_CONV: begin
        is_npu_o  = 1'b1;
        is_conv_o = 1'b1;
        legal     = 1'b1;
      end
      default: ;
    endcase

    if (EXT_ALU == 0 && (opcode == OPCODE_OP || opcode == OPCODE_OP_IMM) &&
        ctrl.alu_control != AluAdd && ctrl.alu_control != AluSub) begin
      legal = 1'b0;
    end

    if (!legal) begin
      ctrl.illegal      = 1'b1;
      ctrl.reg_write_en = 1'b0;
      ctrl.mem_read     = 1'b0;
      ctrl.mem_write    = 1'b0;
      ctrl.branch       = 1'b0;
    end
  end

  assign ctrl_o = ctrl;

endmodule

// File: rtl/decode_dispatch_unit.sv
// Registered, handshaked decode stage with NPU req/done dispatch and timeout.
// Optional DECODE_PERF_CNT_EN adds instruction, NPU-grant and stall counters.
module decode_dispatch_unit
  import osyrys64_pkg::*;
#(
  parameter int unsigned ILEN        = 32,
  parameter int unsigned NPU_TIMEOUT = 1024,
  parameter int unsigned EXT_ALU     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ILEN-1:0]                in_instr,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$bits(decode_ctrl_t)-1:0] out_ctrl,
  output logic                           npu_req_valid,
  input  logic                           npu_req_ready,
  output logic                           npu_req_conv,
  output logic [ILEN-1:0]                npu_req_instr,
  input  logic                           npu_done,
  output logic                           npu_timeout_err
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [63:0]                    perf_instr_cnt,
  output logic [31:0]                    perf_npu_cnt,
  output logic [63:0]                    perf_stall_cnt
`endif
);

  localparam int unsigned CtrlW  = $bits(decode_ctrl_t);
  localparam int unsigned TimerW = $clog2(NPU_TIMEOUT + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(NPU_TIMEOUT - 1);
  localparam logic [TimerW-1:0] TimerMax  = '1;

  logic [CtrlW-1:0]  dec_ctrl;
  logic              dec_is_npu;
  logic              dec_is_conv;

  logic              out_valid_q, out_valid_d;
  logic [CtrlW-1:0]  out_ctrl_q, out_ctrl_d;
  npu_disp_state_t   state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [ILEN-1:0]   req_instr_q, req_instr_d;
  logic              req_conv_q, req_conv_d;
  logic              timeout_err_q, timeout_err_d;

  logic              fire;
  logic              grant;

  instr_decode_comb #(
    .EXT_ALU(EXT_ALU)
  ) u_decode (
    .instr_i  (in_instr[31:0]),
    .ctrl_o   (dec_ctrl),
    .is_npu_o (dec_is_npu),
    .is_conv_o(dec_is_conv)
  );

  assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready) && !flush;
  assign fire     = in_valid && in_ready;
  assign grant    = (state_q == StReq) && npu_req_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_ctrl_d  = out_ctrl_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (fire && !dec_is_npu) begin
      out_valid_d = 1'b1;
      out_ctrl_d  = dec_ctrl;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    req_instr_d   = req_instr_q;
    req_conv_d    = req_conv_q;
    timeout_err_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (fire && dec_is_npu) begin
          state_d     = StReq;
          req_instr_d = in_instr;
          req_conv_d  = dec_is_conv;
        end
      end
      StReq: begin
        // A grant in the same cycle as flush wins: the op is already issued.
        if (grant) begin
          state_d = StWait;
          timer_d = '0;
        end else if (flush) begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (npu_done) begin
          state_d = StIdle;
        end else if (timer_q == TimerLast) begin
          state_d       = StIdle;
          timeout_err_d = 1'b1;
        end else if (timer_q != TimerMax) begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_ctrl_q    <= '0;
      state_q       <= StIdle;
      timer_q       <= '0;
      req_instr_q   <= '0;
      req_conv_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_ctrl_q    <= out_ctrl_d;
      state_q       <= state_d;
      timer_q       <= timer_d;
      req_instr_q   <= req_instr_d;
      req_conv_q    <= req_conv_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_ctrl        = out_ctrl_q;
  assign npu_req_valid   = (state_q == StReq);
  assign npu_req_conv    = req_conv_q;
  assign npu_req_instr   = req_instr_q;
  assign npu_timeout_err = timeout_err_q;

`ifdef DECODE_PERF_CNT_EN
  logic [63:0] perf_instr_q;
  logic [31:0] perf_npu_q;
  logic [63:0] perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_instr_q <= '0;
      perf_npu_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (out_valid_q && out_ready) perf_instr_q <= perf_instr_q + 64'd1;
      if (grant)                    perf_npu_q   <= perf_npu_q + 32'd1;
      if (in_valid && !in_ready)    perf_stall_q <= perf_stall_q + 64'd1;
    end
  end

  assign perf_instr_cnt = perf_instr_q;
  assign perf_npu_cnt   = perf_npu_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_decode_dispatch_unit.sv
// Directed self-checking bench for decode_dispatch_unit (second instance built with EXT_ALU=0).
module tb_decode_dispatch_unit;
  import osyrys64_pkg::*;

  localparam int unsigned CtrlW = $bits(decode_ctrl_t);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, flush;
  logic [31:0]      in_instr;
  logic             out_valid, out_ready;
  logic [CtrlW-1:0] out_ctrl;
  logic             npu_req_valid, npu_req_ready, npu_req_conv, npu_done, npu_timeout_err;
  logic [31:0]      npu_req_instr;

  logic             in_ready_b, out_valid_b, npu_req_valid_b, npu_req_conv_b, npu_timeout_err_b;
  logic [CtrlW-1:0] out_ctrl_b;
  logic [31:0]      npu_req_instr_b;

`ifdef DECODE_PERF_CNT_EN
  logic [63:0] perf_instr_cnt, perf_stall_cnt, perf_instr_cnt_b, perf_stall_cnt_b;
  logic [31:0] perf_npu_cnt, perf_npu_cnt_b;
`endif

  decode_ctrl_t oc, oc_b;
  assign oc   = out_ctrl;
  assign oc_b = out_ctrl_b;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  decode_dispatch_unit #(.ILEN(32), .NPU_TIMEOUT(16), .EXT_ALU(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .npu_req_valid(npu_req_valid), .npu_req_ready(npu_req_ready), .npu_req_conv(npu_req_conv),
    .npu_req_instr(npu_req_instr), .npu_done(npu_done), .npu_timeout_err(npu_timeout_err)
`ifdef DECODE_PERF_CNT_EN
    , .perf_instr_cnt(perf_instr_cnt), .perf_npu_cnt(perf_npu_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  decode_dispatch_unit #(.ILEN(32), .NPU_TIMEOUT(16), .EXT_ALU(0)) dut_base (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_instr(in_instr),
    .flush(flush), .out_valid(out_valid_b), .out_ready(out_ready), .out_ctrl(out_ctrl_b),
    .npu_req_valid(npu_req_valid_b), .npu_req_ready(npu_req_ready),
    .npu_req_conv(npu_req_conv_b), .npu_req_instr(npu_req_instr_b), .npu_done(npu_done),
    .npu_timeout_err(npu_timeout_err_b)
`ifdef DECODE_PERF_CNT_EN
    , .perf_instr_cnt(perf_instr_cnt_b), .perf_npu_cnt(perf_npu_cnt_b),
    .perf_stall_cnt(perf_stall_cnt_b)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_out_ctrl"}, 64'(out_ctrl), 64'd0);
    check_eq({tag, "_req_valid"}, 64'(npu_req_valid), 64'd0);
    check_eq({tag, "_req_conv"}, 64'(npu_req_conv), 64'd0);
    check_eq({tag, "_req_instr"}, 64'(npu_req_instr), 64'd0);
    check_eq({tag, "_tmo_err"}, 64'(npu_timeout_err), 64'd0);
    check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic decode_ctrl_t mk(alu_control_t alu, logic rwe, logic src, logic mr,
                                      logic mw, logic m2r, logic br, logic [4:0] rd,
                                      logic [4:0] rs1, logic [4:0] rs2, logic ill);
    decode_ctrl_t c;
    c = '{alu, rwe, src, mr, mw, m2r, br, rd, rs1, rs2, ill};
    return c;
  endfunction

  logic [31:0]  vec   [13];
  decode_ctrl_t exp_c [13];
  logic [31:0]  ld_w, sd_w, conv_w, mm_w, ill_w, and_w;
  decode_ctrl_t ld_c, sd_c;

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec[0]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    exp_c[0] = mk(AluAdd, 1, 0, 0, 0, 0, 0, 5'd3, 5'd1, 5'd2, 0);
    vec[1]  = enc_r(7'h20, 5'd1, 5'd3, 3'b000, 5'd4);
    exp_c[1] = mk(AluSub, 1, 0, 0, 0, 0, 0, 5'd4, 5'd3, 5'd1, 0);
    vec[2]  = enc_r(7'h00, 5'd2, 5'd4, 3'b100, 5'd5);
    exp_c[2] = mk(AluXor, 1, 0, 0, 0, 0, 0, 5'd5, 5'd4, 5'd2, 0);
    vec[3]  = enc_r(7'h00, 5'd5, 5'd5, 3'b000, 5'd6);
    exp_c[3] = mk(AluAdd, 1, 0, 0, 0, 0, 0, 5'd6, 5'd5, 5'd5, 0);
    vec[4]  = enc_r(7'h20, 5'd3, 5'd6, 3'b000, 5'd7);
    exp_c[4] = mk(AluSub, 1, 0, 0, 0, 0, 0, 5'd7, 5'd6, 5'd3, 0);
    vec[5]  = enc_r(7'h00, 5'd1, 5'd7, 3'b100, 5'd8);
    exp_c[5] = mk(AluXor, 1, 0, 0, 0, 0, 0, 5'd8, 5'd7, 5'd1, 0);
    vec[6]  = enc_r(7'h00, 5'd7, 5'd8, 3'b000, 5'd9);
    exp_c[6] = mk(AluAdd, 1, 0, 0, 0, 0, 0, 5'd9, 5'd8, 5'd7, 0);
    vec[7]  = enc_r(7'h20, 5'd8, 5'd9, 3'b000, 5'd31);
    exp_c[7] = mk(AluSub, 1, 0, 0, 0, 0, 0, 5'd31, 5'd9, 5'd8, 0);
    vec[8]  = enc_i(12'h405, 5'd11, 3'b101, 5'd10, 7'h13);  // srai x10, x11, 5
    exp_c[8] = mk(AluSra, 1, 1, 0, 0, 0, 0, 5'd10, 5'd11, 5'd5, 0);
    vec[9]  = enc_i(12'h003, 5'd13, 3'b101, 5'd12, 7'h13);  // srli x12, x13, 3
    exp_c[9] = mk(AluSrl, 1, 1, 0, 0, 0, 0, 5'd12, 5'd13, 5'd3, 0);
    vec[10] = enc_i(12'h0F0, 5'd15, 3'b111, 5'd14, 7'h13);  // andi x14, x15, 0xf0
    exp_c[10] = mk(AluAnd, 1, 1, 0, 0, 0, 0, 5'd14, 5'd15, 5'd16, 0);
    vec[11] = enc_r(7'h00, 5'd18, 5'd17, 3'b011, 5'd16);     // sltu
    exp_c[11] = mk(AluSltu, 1, 0, 0, 0, 0, 0, 5'd16, 5'd17, 5'd18, 0);
    vec[12] = {7'h00, 5'd2, 5'd1, 3'b001, 5'd8, 7'b1100011}; // bne x1, x2, +8
    exp_c[12] = mk(AluSub, 0, 0, 0, 0, 0, 1, 5'd8, 5'd1, 5'd2, 0);

    ld_w   = enc_i(12'd8, 5'd6, 3'b011, 5'd5, 7'h03);                // ld x5, 8(x6)
    ld_c   = mk(AluAdd, 1, 1, 1, 0, 1, 0, 5'd5, 5'd6, 5'd8, 0);
    sd_w   = {7'h00, 5'd7, 5'd8, 3'b011, 5'd16, 7'b0100011};         // sd x7, 16(x8)
    sd_c   = mk(AluAdd, 0, 1, 0, 1, 0, 0, 5'd16, 5'd8, 5'd7, 0);
    conv_w = 32'h1234_56AB;
    mm_w   = 32'hCAFE_F00B;
    ill_w  = enc_r(7'h7F, 5'd2, 5'd1, 3'b000, 5'd3);
    and_w  = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd3);

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
    npu_req_ready = 1'b0; npu_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check_reset("init");

    // Back-to-back stream with out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      in_instr = vec[i]; in_valid = 1'b1; #1;
      check_eq($sformatf("stream_in_ready_%0d", i), 64'(in_ready), 64'd1);
      tick();
      check_eq($sformatf("stream_out_valid_%0d", i), 64'(out_valid), 64'd1);
      check_eq($sformatf("stream_ctrl_%0d", i), 64'(out_ctrl), 64'(exp_c[i]));
    end
    in_valid = 1'b0;
    tick();
    check_eq("stream_drain", 64'(out_valid), 64'd0);

    // Backpressure: load held for 5 cycles while a store waits.
    out_ready = 1'b0; in_instr = ld_w; in_valid = 1'b1;
    tick();
    in_instr = sd_w;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq($sformatf("bp_in_ready_%0d", k), 64'(in_ready), 64'd0);
      check_eq($sformatf("bp_ctrl_%0d", k), 64'(out_ctrl), 64'(ld_c));
      check_eq($sformatf("bp_valid_%0d", k), 64'(out_valid), 64'd1);
      tick();
    end
    out_ready = 1'b1; #1;
    check_eq("bp_release_ready", 64'(in_ready), 64'd1);
    tick();
    check_eq("bp_second_valid", 64'(out_valid), 64'd1);
    check_eq("bp_second_ctrl", 64'(out_ctrl), 64'(sd_c));
    in_valid = 1'b0;
    tick();
    check_eq("bp_drain", 64'(out_valid), 64'd0);

    // NPU conv: grant after 3 request cycles, done 10 cycles after grant.
    in_instr = conv_w; in_valid = 1'b1; #1;
    check_eq("npu_fire_ready", 64'(in_ready), 64'd1);
    tick();
    in_instr = vec[0];
    npu_done = 1'b1;  // outside WAIT: must be ignored
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq($sformatf("npu_req_valid_%0d", k), 64'(npu_req_valid), 64'd1);
      check_eq($sformatf("npu_req_conv_%0d", k), 64'(npu_req_conv), 64'd1);
      check_eq($sformatf("npu_req_instr_%0d", k), 64'(npu_req_instr), 64'(conv_w));
      check_eq($sformatf("npu_req_in_ready_%0d", k), 64'(in_ready), 64'd0);
      check_eq($sformatf("npu_req_out_valid_%0d", k), 64'(out_valid), 64'd0);
      tick();
      npu_done = 1'b0;
    end
    npu_req_ready = 1'b1;
    tick();
    npu_req_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      #1;
      check_eq($sformatf("npu_wait_in_ready_%0d", k), 64'(in_ready), 64'd0);
      check_eq($sformatf("npu_wait_req_valid_%0d", k), 64'(npu_req_valid), 64'd0);
      check_eq($sformatf("npu_wait_out_valid_%0d", k), 64'(out_valid), 64'd0);
      if (k == 10) npu_done = 1'b1;
      tick();
    end
    npu_done = 1'b0; #1;
    check_eq("npu_after_done_ready", 64'(in_ready), 64'd1);
    check_eq("npu_after_done_err", 64'(npu_timeout_err), 64'd0);
    tick();
    check_eq("npu_after_done_valid", 64'(out_valid), 64'd1);
    check_eq("npu_after_done_ctrl", 64'(out_ctrl), 64'(exp_c[0]));
    in_valid = 1'b0;
    tick();

    // Timeout with NPU_TIMEOUT=16 and no done.
    in_instr = mm_w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; #1;
    check_eq("tmo_req_conv", 64'(npu_req_conv), 64'd0);
    check_eq("tmo_req_instr", 64'(npu_req_instr), 64'(mm_w));
    npu_req_ready = 1'b1;
    tick();
    npu_req_ready = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_eq($sformatf("tmo_err_%0d", k), 64'(npu_timeout_err), (k == 16) ? 64'd1 : 64'd0);
      check_eq($sformatf("tmo_in_ready_%0d", k), 64'(in_ready), (k == 16) ? 64'd1 : 64'd0);
    end
    tick();
    check_eq("tmo_err_single", 64'(npu_timeout_err), 64'd0);

    // Done on the final timeout cycle wins.
    in_instr = mm_w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; npu_req_ready = 1'b1;
    tick();
    npu_req_ready = 1'b0;
    repeat (15) tick();
    npu_done = 1'b1;
    tick();
    npu_done = 1'b0; #1;
    check_eq("tmo_done_err", 64'(npu_timeout_err), 64'd0);
    check_eq("tmo_done_ready", 64'(in_ready), 64'd1);
    tick();
    check_eq("tmo_done_err_late", 64'(npu_timeout_err), 64'd0);

    // Illegal encodings.
    in_instr = ill_w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("ill_valid", 64'(out_valid), 64'd1);
    check_eq("ill_flag", 64'(oc.illegal), 64'd1);
    check_eq("ill_rwe", 64'(oc.reg_write_en), 64'd0);
    check_eq("ill_mem_rw", 64'({oc.mem_read, oc.mem_write, oc.branch}), 64'd0);
    in_instr = and_w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("and_ext_alu", 64'(oc.alu_control), 64'(AluAnd));
    check_eq("and_ext_legal", 64'(oc.illegal), 64'd0);
    check_eq("and_base_valid", 64'(out_valid_b), 64'd1);
    check_eq("and_base_illegal", 64'(oc_b.illegal), 64'd1);
    check_eq("and_base_rwe", 64'(oc_b.reg_write_en), 64'd0);
    tick();

    // Flush in REQ without grant.
    in_instr = mm_w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; #1;
    check_eq("flush_req_before", 64'(npu_req_valid), 64'd1);
    flush = 1'b1; #1;
    check_eq("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0; #1;
    check_eq("flush_req_dropped", 64'(npu_req_valid), 64'd0);
    check_eq("flush_idle_ready", 64'(in_ready), 64'd1);

    // Flush with a same-cycle grant goes to WAIT.
    in_instr = mm_w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b1; npu_req_ready = 1'b1;
    tick();
    flush = 1'b0; npu_req_ready = 1'b0; #1;
    check_eq("flush_grant_req_valid", 64'(npu_req_valid), 64'd0);
    check_eq("flush_grant_wait", 64'(in_ready), 64'd0);
    npu_done = 1'b1;
    tick();
    npu_done = 1'b0; #1;
    check_eq("flush_grant_idle", 64'(in_ready), 64'd1);

    // Flush clears a stalled bundle.
    out_ready = 1'b0; in_instr = vec[2]; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("flush_ov_before", 64'(out_valid), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    check_eq("flush_ov_cleared", 64'(out_valid), 64'd0);

    // Reset with a stalled bundle, then reset in WAIT.
    in_instr = vec[0]; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("rst_ov_before", 64'(out_valid), 64'd1);
    rst = 1'b1; #1;
    check_eq("rst_ov_async", 64'(out_valid), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check_reset("rst_stall");

    out_ready = 1'b1; in_instr = conv_w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; npu_req_ready = 1'b1;
    tick();
    npu_req_ready = 1'b0; #1;
    check_eq("rst_wait_conv_before", 64'(npu_req_conv), 64'd1);
    check_eq("rst_wait_busy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check_reset("rst_wait");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
